// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : CPU load/store unit in front of a single-port synchronous BRAM.
//            Word stores complete in one cycle. Loads take a read-wait cycle.
//            Byte and half stores use read-modify-write through a MERGE cycle.
// Ports    : clk_i, rst_ni          - clock, asynchronous active-low reset
//            req_valid_i/req_ready_o - request handshake
//            req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i
//            resp_valid_o, resp_rdata_o, resp_err_o - one-cycle completion
//            mem_wr_o, mem_addr_o, mem_din_o, mem_dout_i - BRAM port
// Config   : define MAU_MISALIGN_CHECK_EN to reject misaligned half/word
//            accesses. Without it, the low address bits are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR = 10
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [31:0]     req_addr_i,
    input  logic [31:0]     req_wdata_i,
    output logic            resp_valid_o,
    output logic [31:0]     resp_rdata_o,
    output logic            resp_err_o,
    output logic            mem_wr_o,
    output logic [ADDR-1:0] mem_addr_o,
    output logic [31:0]     mem_din_o,
    input  logic [31:0]     mem_dout_i
);

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;
    localparam logic [1:0] c_SIZE_ILL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        MERGE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [1:0]      lane_q, lane_d;
    logic [1:0]      size_q, size_d;
    logic            we_q, we_d;
    logic            uns_q, uns_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;

    logic            w_accept;
    logic            w_misalign;
    logic            w_err;
    logic            w_mem_wr;
    logic [ADDR-1:0] w_mem_addr;
    logic [31:0]     w_mem_din;
    logic            w_unused_addr;

    // Address bits above the BRAM range are dropped, so accesses wrap.
    assign w_unused_addr = ^req_addr_i[31:ADDR+2];

    // Pick the addressed lane and extend it. A half uses only lane[1], which
    // also gives the forced alignment when the misalign check is disabled.
    function automatic logic [31:0] f_load(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [1:0]  size,
                                           input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            c_SIZE_BYTE: f_load = {{24{~uns & b[7]}}, b};
            c_SIZE_HALF: f_load = {{16{~uns & h[15]}}, h};
            default:     f_load = word;
        endcase
    endfunction

    // Replace the addressed byte or half of the word read from the BRAM.
    function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                            input logic [15:0] wdata,
                                            input logic [1:0]  lane,
                                            input logic [1:0]  size);
        logic [31:0] w;
        w = old_word;
        if (size == c_SIZE_BYTE) begin
            w[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (lane[1]) begin
            w[31:16] = wdata;
        end else begin
            w[15:0] = wdata;
        end
        f_merge = w;
    endfunction

    assign w_accept = req_valid_i && (state_q == IDLE);

`ifdef MAU_MISALIGN_CHECK_EN
    assign w_misalign = ((req_size_i == c_SIZE_HALF) && req_addr_i[0]) ||
                        ((req_size_i == c_SIZE_WORD) && (req_addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = (req_size_i == c_SIZE_ILL) || w_misalign;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lane_d       = lane_q;
        size_d       = size_q;
        we_d         = we_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        w_mem_wr     = 1'b0;
        w_mem_addr   = addr_q;
        w_mem_din    = wdata_q;

        case (state_q)
            IDLE: begin
                // The BRAM sees the raw request so it can read or write in
                // the accept cycle itself.
                w_mem_addr = req_addr_i[ADDR+1:2];
                w_mem_din  = req_wdata_i;
                if (w_accept) begin
                    addr_d  = req_addr_i[ADDR+1:2];
                    lane_d  = req_addr_i[1:0];
                    size_d  = req_size_i;
                    we_d    = req_we_i;
                    uns_d   = req_unsigned_i;
                    wdata_d = req_wdata_i;
                    if (w_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we_i && (req_size_i == c_SIZE_WORD)) begin
                        w_mem_wr     = 1'b1;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (we_q) begin
                    state_d = MERGE;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = f_load(mem_dout_i, lane_q, size_q, uns_q);
                    state_d      = IDLE;
                end
            end
            MERGE: begin
                // The address was re-presented during RD_WAIT, so the read
                // data is still the unmodified word here.
                w_mem_wr     = 1'b1;
                w_mem_din    = f_merge(mem_dout_i, wdata_q[15:0], lane_q, size_q);
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            lane_q       <= 2'd0;
            size_q       <= 2'd0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            we_q         <= we_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;
    // The write strobe is gated so that no write escapes while in reset.
    assign mem_wr_o     = w_mem_wr & rst_ni;
    assign mem_addr_o   = w_mem_addr;
    assign mem_din_o    = w_mem_din;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit with a BRAM model and a
//            response scoreboard checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int ADDR = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [1:0]      req_size = 2'd0;
    logic            req_unsigned = 1'b0;
    logic [31:0]     req_addr = 32'd0;
    logic [31:0]     req_wdata = 32'd0;
    logic            resp_valid;
    logic [31:0]     resp_rdata;
    logic            resp_err;
    logic            mem_wr;
    logic [ADDR-1:0] mem_addr;
    logic [31:0]     mem_din;
    logic [31:0]     mem_dout;

    logic [31:0]     mem [0:(1<<ADDR)-1];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mem_access_unit #(.ADDR(ADDR)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .mem_wr_o       (mem_wr),
        .mem_addr_o     (mem_addr),
        .mem_din_o      (mem_din),
        .mem_dout_i     (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read, write-first BRAM.
    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr] <= mem_din;
            mem_dout      <= mem_din;
        end else begin
            mem_dout <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest expectation, in cycle.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=valid(rdata=%h) required=none", resp_rdata);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called #1 after a rising edge with the unit expected idle or soon idle.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat);
        int waitc;
        waitc        = 0;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        while (!req_ready && waitc < 20) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        if (!req_ready) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
        sb.push_back('{exp_rdata, exp_err, cyc + lat});
        #0;
        if (exp_err) chk("mem_wr_on_err", {31'd0, mem_wr}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: a pending word store must not reach the BRAM.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_addr  = 32'h40; req_wdata = 32'h99;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk); #1;

        // Word store then word load.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        req_addr = 32'h10; #1;
        chk("load_mem_addr", 32'(mem_addr), 32'd4);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        // Byte RMW and byte loads.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 1);
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000007F, 32'h0, 1'b0, 3);
        drain();
        chk("bram_byte_merge", mem[4], 32'h7F223344);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h0000007F, 1'b0, 2);
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFF80, 32'h0, 1'b0, 3);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 2);
        issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'h00000033, 1'b0, 2);
        issue(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 32'h00000022, 1'b0, 2);

        // Half RMW and half loads.
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1);
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000ABCD, 32'h0, 1'b0, 3);
        drain();
        chk("bram_half_merge", mem[8], 32'hABCD0000);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'hFFFFABCD, 1'b0, 2);
        issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h0000ABCD, 1'b0, 2);
        issue(1'b1, 2'd1, 1'b0, 32'h20, 32'h00001234, 32'h0, 1'b0, 3);
        drain();
        chk("bram_half_low", mem[8], 32'hABCD1234);

        // Misaligned accesses.
`ifdef MAU_MISALIGN_CHECK_EN
        issue(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b0, 2'd2, 1'b1, 32'h23, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, 2'd1, 1'b0, 32'h21, 32'h5555, 32'h0, 1'b1, 1);
        drain();
        chk("bram_misalign_nowrite", mem[8], 32'hABCD1234);
`else
        issue(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 32'h00001234, 1'b0, 2);
        issue(1'b0, 2'd2, 1'b1, 32'h23, 32'h0, 32'hABCD1234, 1'b0, 2);
`endif

        // Illegal size never writes.
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80223344, 1'b0, 2);

        // Address wrap.
        req_addr = 32'h1010; #1;
        chk("wrap_mem_addr", 32'(mem_addr), 32'd4);
        issue(1'b0, 2'd2, 1'b0, 32'h1010, 32'h0, 32'h80223344, 1'b0, 2);

        // Back-to-back word stores.
        drain();
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ready", {31'd0, req_ready}, 32'd1);
            issue(1'b1, 2'd2, 1'b0, 32'(i * 4), 32'(i), 32'h0, 1'b0, 1);
        end
        issue(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, 32'd3, 1'b0, 2);
        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'd1, 1'b0, 2);
        drain();

        // Reset during MERGE of a byte store.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("merge_wr_before_reset", {31'd0, mem_wr}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("merge_wr_in_reset", {31'd0, mem_wr}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_bram_unchanged", mem[4], 32'h80223344);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80223344, 1'b0, 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
